cv32e40x_xif_result_queue: RTL and testbench
============================================

Name: cv32e40x_xif_result_queue

Overview:
In-order result reorder/hold queue between the XIF AES functional unit and the core's XIF result interface. It records each offloaded instruction when the issue stage accepts it, captures the FU result, and tracks the commit/kill decision per instruction. Results are released to the core strictly in issue order, and only after commit; results of killed instructions are dropped silently. This decouples FU completion from commit timing and from result_ready backpressure.

Parameters:
X_ID_WIDTH, 4, width of XIF instruction ID
X_RFW_WIDTH, 32, width of result data
DEPTH, 4, number of in-flight entries; power of two, 2..16

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
alloc_valid_i  in  1  issue stage accepted an offloaded instruction this cycle
alloc_ready_o  out  1  queue can take an allocation (not full)
alloc_id_i  in  X_ID_WIDTH  ID of accepted instruction
alloc_rd_i  in  5  destination register (instr[11:7])
commit_valid_i  in  1  XIF commit strobe
commit_id_i  in  X_ID_WIDTH  ID being committed/killed
commit_kill_i  in  1  1 = kill, 0 = commit
fu_valid_i  in  1  FU result valid
fu_ready_o  out  1  an allocated entry is awaiting FU data
fu_data_i  in  X_RFW_WIDTH  FU result
result_valid_o  out  1  XIF result_valid
result_ready_i  in  1  XIF result_ready
result_id_o  out  X_ID_WIDTH  XIF result.id
result_rd_o  out  5  XIF result.rd
result_data_o  out  X_RFW_WIDTH  XIF result.data
result_we_o  out  1  XIF result.we
count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: circular buffer; per entry valid, id, rd, data, has_data, committed, killed. Pointers: head (oldest), tail (next alloc), fu_ptr (oldest entry without data); counters count and fu_pending.
- Reset (rst_n=0 at clock edge): all entry flags cleared, pointers and counters 0. Outputs: alloc_ready_o=1, fu_ready_o=0, result_valid_o=0, result_id_o/rd_o/data_o=0, result_we_o=0, count_o=0. Reset mid-operation discards all entries with no result emitted.
- Allocation: fires when alloc_valid_i && alloc_ready_o. Writes id/rd at tail, clears flags, sets valid, advances tail with wrap at DEPTH. alloc_ready_o = (count != DEPTH) and depends only on registered state; no same-cycle pop bypass when full.
- FU capture: fires when fu_valid_i && fu_ready_o. Writes data at fu_ptr, sets has_data, advances fu_ptr. fu_ready_o = (fu_pending != 0). FU results arrive in allocation order. An allocation and FU capture on the same cycle into the same empty slot are not allowed, because fu_ready_o is registered-state based.
- Commit: when commit_valid_i, the valid, undecided entry with id == commit_id_i gets committed=1, or killed=1 if commit_kill_i. The same-cycle allocation is also matched against alloc_id_i, so commit on the allocation cycle works. No match, or an already decided entry: ignored, no state change. Duplicate live IDs are illegal; a bench assertion covers this.
- Release (combinational from registered head state): result_valid_o = head valid && has_data && committed && !killed. result_id_o, result_rd_o and result_data_o come from the head entry, and result_we_o = result_valid_o. They are held stable while result_valid_o && !result_ready_i.
- Pop: on result_valid_o && result_ready_i; or silently, without asserting result_valid_o, when head valid && has_data && killed. At most one pop per cycle. A pop clears valid and advances head.
- count_o = allocations minus pops. Simultaneous alloc and pop keeps the count unchanged.
- Latency: FU capture at cycle N with commit at or before N gives result_valid_o at N+1. Commit at N after data is present gives result_valid_o at N+1.
- A killed entry with no data yet stays at its position. Its later FU result is absorbed and then dropped, which keeps FU ordering intact.

Test Plan:
1. Reset, alloc id=3 rd=5, commit id=3 in the same cycle, FU data 0xDEADBEEF one cycle later, result_ready_i=1 -> result_valid_o one cycle after FU capture with id=3, rd=5, data=0xDEADBEEF; count_o returns to 0.
2. Alloc ids 1,2,3,4 (DEPTH=4) -> alloc_ready_o=0, count_o=4. Alloc attempt id=5 is not taken. After one release, alloc_ready_o=1.
3. Alloc ids 1,2; FU data A and B; commit 2 before 1 -> no result until commit 1. Then results in order: id1=A, then id2=B.
4. Alloc ids 1,2; kill 1, commit 2; FU data A, B -> A never appears. Only id=2 with data=B is emitted, and count_o reaches 0.
5. Result committed, result_ready_i held 0 for 5 cycles -> result_valid_o stays 1 and id/rd/data stay constant. The pop happens on the cycle ready=1.
6. Three entries in flight, rst_n=0 for one edge -> all outputs at reset values. A later FU/commit for old IDs is ignored, and no result is emitted.

Source files
------------

// File: rtl/cv32e40x_xif_result_queue.sv
// In-order hold queue between the XIF AES unit and the core result interface.
// Results leave in issue order and only after commit. Killed results are dropped.
module cv32e40x_xif_result_queue #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [X_ID_WIDTH-1:0]    alloc_id_i,
    input  logic [4:0]               alloc_rd_i,
    input  logic                     commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]    commit_id_i,
    input  logic                     commit_kill_i,
    input  logic                     fu_valid_i,
    output logic                     fu_ready_o,
    input  logic [X_RFW_WIDTH-1:0]   fu_data_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [X_ID_WIDTH-1:0]    result_id_o,
    output logic [4:0]               result_rd_o,
    output logic [X_RFW_WIDTH-1:0]   result_data_o,
    output logic                     result_we_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0]        valid_q, has_data_q, committed_q, killed_q;
    logic [X_ID_WIDTH-1:0]   id_q   [DEPTH];
    logic [4:0]              rd_q   [DEPTH];
    logic [X_RFW_WIDTH-1:0]  data_q [DEPTH];
    logic [PW-1:0]           head_q, tail_q, fu_ptr_q;
    logic [CW-1:0]           count_q, fu_pending_q;

    logic alloc_fire, fu_fire, head_done, pop_kill, pop, alloc_hit;

    assign alloc_ready_o = (count_q != FULL);
    assign fu_ready_o    = (fu_pending_q != '0);
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign fu_fire       = fu_valid_i && fu_ready_o;
    assign alloc_hit     = commit_valid_i && (alloc_id_i == commit_id_i);

    assign head_done      = valid_q[head_q] && has_data_q[head_q];
    assign result_valid_o = head_done && committed_q[head_q] && !killed_q[head_q];
    assign pop_kill       = head_done && killed_q[head_q];
    assign pop            = (result_valid_o && result_ready_i) || pop_kill;

    // Payload is zeroed while not presenting, so reset values need no storage reset.
    assign result_id_o   = result_valid_o ? id_q[head_q]   : '0;
    assign result_rd_o   = result_valid_o ? rd_q[head_q]   : '0;
    assign result_data_o = result_valid_o ? data_q[head_q] : '0;
    assign result_we_o   = result_valid_o;
    assign count_o       = count_q;

    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            id_q[tail_q] <= alloc_id_i;
            rd_q[tail_q] <= alloc_rd_i;
        end
        if (fu_fire) begin
            data_q[fu_ptr_q] <= fu_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            valid_q      <= '0;
            has_data_q   <= '0;
            committed_q  <= '0;
            killed_q     <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            fu_ptr_q     <= '0;
            count_q      <= '0;
            fu_pending_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && valid_q[i] && !committed_q[i] && !killed_q[i] &&
                    (id_q[i] == commit_id_i)) begin
                    if (commit_kill_i) killed_q[i] <= 1'b1;
                    else               committed_q[i] <= 1'b1;
                end
            end

            // The tail slot is free whenever allocation fires, so the loop above never touches it.
            if (alloc_fire) begin
                valid_q[tail_q]     <= 1'b1;
                has_data_q[tail_q]  <= 1'b0;
                committed_q[tail_q] <= alloc_hit && !commit_kill_i;
                killed_q[tail_q]    <= alloc_hit && commit_kill_i;
                tail_q              <= tail_q + 1'b1;
            end

            if (fu_fire) begin
                has_data_q[fu_ptr_q] <= 1'b1;
                fu_ptr_q             <= fu_ptr_q + 1'b1;
            end

            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end

            if (alloc_fire && !pop)      count_q <= count_q + 1'b1;
            else if (!alloc_fire && pop) count_q <= count_q - 1'b1;

            if (alloc_fire && !fu_fire)      fu_pending_q <= fu_pending_q + 1'b1;
            else if (!alloc_fire && fu_fire) fu_pending_q <= fu_pending_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_cv32e40x_xif_result_queue.sv
// Directed bench for the XIF result queue with an in-order expected-result scoreboard.
module tb_cv32e40x_xif_result_queue;
    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        alloc_valid_i, alloc_ready_o;
    logic [3:0]  alloc_id_i;
    logic [4:0]  alloc_rd_i;
    logic        commit_valid_i, commit_kill_i;
    logic [3:0]  commit_id_i;
    logic        fu_valid_i, fu_ready_o;
    logic [31:0] fu_data_i;
    logic        result_valid_o, result_ready_i, result_we_o;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic [2:0]  count_o;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    bit   live[16];
    int   tests = 0;
    int   fails = 0;

    cv32e40x_xif_result_queue #(
        .X_ID_WIDTH (4),
        .X_RFW_WIDTH(32),
        .DEPTH      (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .alloc_valid_i (alloc_valid_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_id_i    (alloc_id_i),
        .alloc_rd_i    (alloc_rd_i),
        .commit_valid_i(commit_valid_i),
        .commit_id_i   (commit_id_i),
        .commit_kill_i (commit_kill_i),
        .fu_valid_i    (fu_valid_i),
        .fu_ready_o    (fu_ready_o),
        .fu_data_i     (fu_data_i),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .result_id_o   (result_id_o),
        .result_rd_o   (result_rd_o),
        .result_data_o (result_data_o),
        .result_we_o   (result_we_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every handshake the DUT completes against the scoreboard head.
    task automatic monitor();
        exp_t e;
        if (result_valid_o && result_ready_i) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_result: observed id %0h data %0h, expected no result",
                       result_id_o, result_data_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_id", 64'(result_id_o), 64'(e.id));
                chk("res_rd", 64'(result_rd_o), 64'(e.rd));
                chk("res_data", 64'(result_data_o), 64'(e.data));
                chk("res_we", 64'(result_we_o), 64'd1);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_alloc(input logic [3:0] id, input logic [4:0] rd);
        tests++;
        assert (!live[id]) else begin
            fails++;
            $error("FAIL dup_live_id: observed id %0h already live, expected unique", id);
        end
        live[id]      = 1'b1;
        alloc_valid_i = 1'b1;
        alloc_id_i    = id;
        alloc_rd_i    = rd;
        tick();
        alloc_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic do_fu(input logic [31:0] d);
        fu_valid_i = 1'b1;
        fu_data_i  = d;
        tick();
        fu_valid_i = 1'b0;
    endtask

    task automatic clear_live();
        foreach (live[i]) live[i] = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_alloc_ready"}, 64'(alloc_ready_o), 64'd1);
        chk({tag, "_fu_ready"}, 64'(fu_ready_o), 64'd0);
        chk({tag, "_valid"}, 64'(result_valid_o), 64'd0);
        chk({tag, "_id"}, 64'(result_id_o), 64'd0);
        chk({tag, "_rd"}, 64'(result_rd_o), 64'd0);
        chk({tag, "_data"}, 64'(result_data_o), 64'd0);
        chk({tag, "_we"}, 64'(result_we_o), 64'd0);
        chk({tag, "_count"}, 64'(count_o), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid_i = 1'b0; alloc_id_i = '0; alloc_rd_i = '0;
        commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
        fu_valid_i = 1'b0; fu_data_i = '0; result_ready_i = 1'b1;
        clear_live();
        tick();
        tick();
        check_reset("rst");
        rst_n = 1'b1;

        // 1: commit on the allocation cycle, data one cycle later
        alloc_valid_i = 1'b1; alloc_id_i = 4'd3; alloc_rd_i = 5'd5; live[3] = 1'b1;
        commit_valid_i = 1'b1; commit_id_i = 4'd3;
        tick();
        alloc_valid_i = 1'b0; commit_valid_i = 1'b0;
        chk("t1_fu_ready", 64'(fu_ready_o), 64'd1);
        chk("t1_count1", 64'(count_o), 64'd1);
        chk("t1_no_early", 64'(result_valid_o), 64'd0);
        sb.push_back('{id: 4'd3, rd: 5'd5, data: 32'hDEADBEEF});
        do_fu(32'hDEADBEEF);
        chk("t1_latency", 64'(result_valid_o), 64'd1);
        chk("t1_id", 64'(result_id_o), 64'd3);
        tick();
        chk("t1_count0", 64'(count_o), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        clear_live();

        // 2: fill to DEPTH, reject the extra allocation, free a slot
        do_alloc(4'd1, 5'd1);
        do_alloc(4'd2, 5'd2);
        do_alloc(4'd3, 5'd3);
        do_alloc(4'd4, 5'd4);
        chk("t2_full_ready", 64'(alloc_ready_o), 64'd0);
        chk("t2_full_count", 64'(count_o), 64'd4);
        alloc_valid_i = 1'b1; alloc_id_i = 4'd5; alloc_rd_i = 5'd6;
        tick();
        alloc_valid_i = 1'b0;
        chk("t2_reject_count", 64'(count_o), 64'd4);
        do_commit(4'd1, 1'b0);
        sb.push_back('{id: 4'd1, rd: 5'd1, data: 32'h1111_0001});
        do_fu(32'h1111_0001);
        chk("t2_no_bypass", 64'(alloc_ready_o), 64'd0);
        tick();
        chk("t2_ready_after", 64'(alloc_ready_o), 64'd1);
        chk("t2_count3", 64'(count_o), 64'd3);
        do_commit(4'd2, 1'b1);
        do_commit(4'd3, 1'b1);
        do_commit(4'd4, 1'b1);
        do_fu(32'h2222_0002);
        do_fu(32'h3333_0003);
        do_fu(32'h4444_0004);
        tick();
        tick();
        chk("t2_drain_count", 64'(count_o), 64'd0);
        chk("t2_drain_fu_ready", 64'(fu_ready_o), 64'd0);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);
        clear_live();

        // 3: out-of-order commit, in-order release
        do_alloc(4'd1, 5'd7);
        do_alloc(4'd2, 5'd8);
        do_fu(32'hAAAA_0001);
        do_fu(32'hBBBB_0002);
        do_commit(4'd2, 1'b0);
        chk("t3_blocked0", 64'(result_valid_o), 64'd0);
        tick();
        chk("t3_blocked1", 64'(result_valid_o), 64'd0);
        sb.push_back('{id: 4'd1, rd: 5'd7, data: 32'hAAAA_0001});
        sb.push_back('{id: 4'd2, rd: 5'd8, data: 32'hBBBB_0002});
        do_commit(4'd1, 1'b0);
        chk("t3_release_valid", 64'(result_valid_o), 64'd1);
        chk("t3_release_id", 64'(result_id_o), 64'd1);
        tick();
        tick();
        chk("t3_count0", 64'(count_o), 64'd0);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);
        clear_live();

        // 4: killed entry is dropped silently
        do_alloc(4'd1, 5'd9);
        do_alloc(4'd2, 5'd10);
        do_commit(4'd1, 1'b1);
        do_commit(4'd2, 1'b0);
        sb.push_back('{id: 4'd2, rd: 5'd10, data: 32'hB0B0_B0B0});
        do_fu(32'hA0A0_A0A0);
        chk("t4_kill_hidden", 64'(result_valid_o), 64'd0);
        do_fu(32'hB0B0_B0B0);
        chk("t4_id2_valid", 64'(result_valid_o), 64'd1);
        tick();
        chk("t4_count0", 64'(count_o), 64'd0);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);
        clear_live();

        // 5: backpressure holds the result stable
        result_ready_i = 1'b0;
        alloc_valid_i = 1'b1; alloc_id_i = 4'd6; alloc_rd_i = 5'd11; live[6] = 1'b1;
        commit_valid_i = 1'b1; commit_id_i = 4'd6;
        tick();
        alloc_valid_i = 1'b0; commit_valid_i = 1'b0;
        sb.push_back('{id: 4'd6, rd: 5'd11, data: 32'hC0FF_EE55});
        do_fu(32'hC0FF_EE55);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 64'(result_valid_o), 64'd1);
            chk("t5_hold_id", 64'(result_id_o), 64'd6);
            chk("t5_hold_rd", 64'(result_rd_o), 64'd11);
            chk("t5_hold_data", 64'(result_data_o), 64'hC0FF_EE55);
            chk("t5_hold_count", 64'(count_o), 64'd1);
            tick();
        end
        result_ready_i = 1'b1;
        tick();
        chk("t5_pop_valid", 64'(result_valid_o), 64'd0);
        chk("t5_pop_count", 64'(count_o), 64'd0);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        clear_live();

        // 6: reset mid-operation discards in-flight entries
        do_alloc(4'd1, 5'd1);
        do_alloc(4'd2, 5'd2);
        do_alloc(4'd3, 5'd3);
        do_fu(32'h0000_0111);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_live();
        check_reset("t6_rst");
        commit_valid_i = 1'b1; commit_id_i = 4'd1;
        fu_valid_i = 1'b1; fu_data_i = 32'h0000_0222;
        tick();
        fu_valid_i = 1'b0;
        commit_id_i = 4'd2;
        tick();
        commit_valid_i = 1'b0;
        tick();
        tick();
        chk("t6_stale_valid", 64'(result_valid_o), 64'd0);
        chk("t6_stale_count", 64'(count_o), 64'd0);
        chk("t6_stale_fu_ready", 64'(fu_ready_o), 64'd0);
        alloc_valid_i = 1'b1; alloc_id_i = 4'd4; alloc_rd_i = 5'd12; live[4] = 1'b1;
        commit_valid_i = 1'b1; commit_id_i = 4'd4;
        tick();
        alloc_valid_i = 1'b0; commit_valid_i = 1'b0;
        sb.push_back('{id: 4'd4, rd: 5'd12, data: 32'h0000_0444});
        do_fu(32'h0000_0444);
        tick();
        chk("t6_after_count", 64'(count_o), 64'd0);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
